// File: rtl/data_mem_dma.sv
// data_mem_dma: owns the single port of data_memory. The CPU MEM stage always
// wins the port; a small byte-copy DMA engine uses only cycles the CPU leaves
// idle. The CPU's last load value is held locally so DMA reads, which reuse
// the memory's read_data register, are never visible to the CPU.
//
// Handshake: there is no backpressure towards the CPU. A CPU access in a cycle
// (cpu_mem_read | cpu_mem_write) owns the port in that same cycle; load data
// is presented on cpu_read_data in the following cycle and held until the next
// load. dma_start is accepted only in IDLE; dma_done is a one-cycle pulse.
module data_mem_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic [DATA_W-1:0] cpu_read_data,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [ADDR_W-1:0] dma_len,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              rd_pend_q, rd_pend_d;

  logic              cpu_active;
  logic              dma_rd_req;
  logic              dma_wr_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign cpu_active = cpu_mem_read | cpu_mem_write;
  // Address arithmetic wraps naturally at ADDR_W bits.
  assign rd_addr    = src_q + idx_q;
  assign wr_addr    = dst_q + idx_q;

  assign dma_busy   = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_WR);
  assign dma_done   = (state_q == S_DONE);

  // Copy FSM next-state: each byte is RD (issue read), CAP (grab data), WR.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    dma_rd_req = 1'b0;
    dma_wr_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dma_start) begin
          if (dma_len != '0) begin
            src_d   = dma_src;
            dst_d   = dma_dst;
            len_d   = dma_len;
            idx_d   = '0;
            state_d = S_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD: begin
        if (!cpu_active) begin
          dma_rd_req = 1'b1;
          state_d    = S_CAP;
        end
      end
      S_CAP: begin
        // Read data registered by the memory is valid now even if the CPU
        // is using the port this cycle; its own data only lands next cycle.
        buf_d   = mem_read_data;
        state_d = S_WR;
      end
      S_WR: begin
        if (!cpu_active) begin
          dma_wr_req = 1'b1;
          if (idx_q == (len_q - ONE)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ONE;
            state_d = S_RD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Port mux: CPU passes through untouched whenever it is active.
  always_comb begin
    if (cpu_active) begin
      mem_read       = cpu_mem_read;
      mem_write      = cpu_mem_write;
      mem_address    = cpu_address;
      mem_write_data = cpu_write_data;
    end else begin
      mem_read       = dma_rd_req;
      mem_write      = dma_wr_req;
      mem_address    = (state_q == S_WR) ? wr_addr : rd_addr;
      mem_write_data = buf_q;
    end
  end

  // CPU load result: live memory data in the cycle after a CPU read, else held.
  always_comb begin
    rd_pend_d     = cpu_mem_read;
    hold_d        = rd_pend_q ? mem_read_data : hold_q;
    cpu_read_data = rd_pend_q ? mem_read_data : hold_q;
  end

  // State and datapath registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      buf_q     <= '0;
      hold_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
    end
  end

endmodule
